// File: rtl/lz_pkg.sv
// Shared constants for the leading-zero stream generator: FSM encoding, size defaults, LFSR.
// Latency: none; definitions only.
// Backpressure: none; definitions only.
package lz_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int WORD_DEF  = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_SEND = 2'd2;
   localparam logic [1:0] ST_GAP  = 2'd3;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form: exponent k taps bit 16-k.
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   // One LFSR step: feedback enters at the MSB, register shifts toward bit 0.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {^(s & LFSR_TAPS), s[15:1]};
   endfunction

endpackage

// File: rtl/lz_lfsr16.sv
// 16-bit Fibonacci LFSR supplying the random fill below the leading one.
// Latency: VALUE reflects a STEP one clock after the edge that samples it.
// Backpressure: none; holds its value whenever STEP is low.
module lz_lfsr16 (
   input  logic        CLK,
   input  logic        RST,
   input  logic        STEP,
   output logic [15:0] VALUE
);
   import lz_pkg::*;

   logic [15:0] val_q;
   logic [15:0] val_d;

   // Advance only when the parent accepts a request.
   always_comb begin
      val_d = val_q;
      if (STEP) begin
         val_d = lfsr_next(val_q);
      end
   end

   // Shift register, seeded on reset so the sequence restarts identically.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         val_q <= LFSR_SEED;
      end else begin
         val_q <= val_d;
      end
   end

   assign VALUE = val_q;

endmodule

// File: rtl/lz_stream_gen.sv
// Builds a word with n leading zeros, a one, then LFSR fill, and streams it MSB byte first.
// Latency: first byte two cycles after the START sample edge (IDLE->LOAD->SEND), then B bytes back to back.
// Backpressure: none; START is ignored while BUSY, over-range requests pulse ERR.
module lz_stream_gen #(
   parameter int WIDTH = lz_pkg::WIDTH_DEF,
   parameter int WORD  = lz_pkg::WORD_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [5:0]       ZEROS_IN,
   input  logic             MODE_IN,
   output logic [WIDTH-1:0] DATA,
   output logic             IVALID,
   output logic             MODE,
   output logic             BUSY,
   output logic             DONE,
   output logic             ERR
);
   import lz_pkg::*;

   localparam int WW = WIDTH * WORD;
   localparam int CW = $clog2(WORD) + 1;
   localparam int IW = $clog2(WW);

   logic [1:0]    state_q, state_d;
   logic [5:0]    zeros_q, zeros_d;
   logic          mode_q,  mode_d;
   logic          err_q,   err_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic [CW-1:0] last_q,  last_d;
   logic [WW-1:0] word_q,  word_d;

   logic [15:0]   lfsr_val;
   logic          req_ok;
   logic          accept;
   logic          send;
   logic [WW-1:0] top_bit;
   logic [WW-1:0] low_mask;
   logic [WW-1:0] fill;
   logic [IW-1:0] sel_lsb;

   // Index of the last byte to send: whole word, or just up to the byte holding the leading one.
   function automatic logic [CW-1:0] last_index(input logic [5:0] n, input logic m);
      int b;
      if (!m || int'(n) == WW) begin
         b = WORD;
      end else begin
         b = int'(n) / WIDTH + 1;
      end
      return CW'(b - 1);
   endfunction

   assign req_ok   = (int'(ZEROS_IN) <= WW);
   assign accept   = (state_q == ST_IDLE) && START && req_ok;
   assign top_bit  = {1'b1, {(WW-1){1'b0}}};
   assign low_mask = {1'b0, {(WW-1){1'b1}}};
   assign fill     = WW'({lfsr_val, ~lfsr_val});

   // The LFSR steps on the accept edge, so LOAD sees the freshly advanced value.
   lz_lfsr16 u_lfsr (
      .CLK   (CLK),
      .RST   (RST),
      .STEP  (accept),
      .VALUE (lfsr_val)
   );

   // Request FSM: latch the request, build the word, walk the bytes, one idle gap.
   always_comb begin
      state_d = state_q;
      zeros_d = zeros_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      word_d  = word_q;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               if (req_ok) begin
                  state_d = ST_LOAD;
                  zeros_d = ZEROS_IN;
                  mode_d  = MODE_IN;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            // A shift by the full word width clears both terms, giving all zeros for n = WW.
            word_d  = (top_bit >> zeros_q) | (fill & (low_mask >> zeros_q));
            last_d  = last_index(zeros_q, mode_q);
            cnt_d   = '0;
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (cnt_q == last_q) begin
               cnt_d   = '0;
               state_d = ST_GAP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_GAP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // All state clears asynchronously; outputs decode from it, so reset silences them at once.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         zeros_q <= '0;
         mode_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         last_q  <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         zeros_q <= zeros_d;
         mode_q  <= mode_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         word_q  <= word_d;
      end
   end

   // Byte mux: MSB byte first, forced to zero outside SEND.
   always_comb begin
      send    = (state_q == ST_SEND);
      sel_lsb = IW'(WW - WIDTH - int'(cnt_q) * WIDTH);
      DATA    = '0;
      if (send) begin
         DATA = word_q[sel_lsb +: WIDTH];
      end
   end

   assign IVALID = send;
   assign MODE   = mode_q;
   assign BUSY   = (state_q != ST_IDLE);
   assign DONE   = (state_q == ST_GAP);
   assign ERR    = err_q;

endmodule

// File: tb/tb_lz_stream_gen.sv
// Directed bench for lz_stream_gen with an independent LFSR/word model and a leading-zero count of the received word.
// Latency: first byte expected on the second clock after START is sampled.
// Backpressure: checks that START during a burst is ignored.
module tb_lz_stream_gen;

   logic       CLK = 1'b0;
   logic       RST;
   logic       START;
   logic [5:0] ZEROS_IN;
   logic       MODE_IN;
   logic [7:0] DATA;
   logic       IVALID;
   logic       MODE;
   logic       BUSY;
   logic       DONE;
   logic       ERR;

   int          errors = 0;
   int          checks = 0;
   logic [15:0] lfsr_m;

   lz_stream_gen #(.WIDTH(8), .WORD(4)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .START    (START),
      .ZEROS_IN (ZEROS_IN),
      .MODE_IN  (MODE_IN),
      .DATA     (DATA),
      .IVALID   (IVALID),
      .MODE     (MODE),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .ERR      (ERR)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      logic fb;
      fb = s[0] ^ s[2] ^ s[3] ^ s[5];
      return {fb, s[15:1]};
   endfunction

   function automatic logic [31:0] model_word(input int n, input logic [15:0] l);
      logic [31:0] one_bit, mask, fill;
      if (n >= 32) return 32'h0;
      one_bit = 32'h8000_0000 >> n;
      mask    = 32'h7FFF_FFFF >> n;
      fill    = {l, ~l};
      return one_bit | (fill & mask);
   endfunction

   function automatic int clz(input logic [31:0] w);
      for (int i = 31; i >= 0; i--) begin
         if (w[i]) return 31 - i;
      end
      return 32;
   endfunction

   // Issue one request from a negedge and watch a fixed 10-cycle window after LOAD.
   task automatic do_req(input logic [5:0] n, input logic m, input bit poke,
                         output int nb, output logic [31:0] rx, output int ndone);
      int first_cyc, bubbles, dirty, mflip;
      nb = 0; rx = '0; ndone = 0; first_cyc = -1; bubbles = 0; dirty = 0; mflip = 0;
      ZEROS_IN = n; MODE_IN = m; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      check("load_busy", BUSY, 1);
      check("load_ivalid", IVALID, 0);
      check("mode_latch", MODE, m);
      for (int c = 1; c <= 10; c++) begin
         @(negedge CLK);
         START = 1'b0;
         if (IVALID) begin
            if (first_cyc < 0) first_cyc = c;
            else if (c != first_cyc + nb) bubbles++;
            if (nb < 4) rx[31 - 8*nb -: 8] = DATA;
            nb++;
            if (MODE !== m) mflip++;
            if (poke && nb == 1) begin
               ZEROS_IN = 6'd0; MODE_IN = ~m; START = 1'b1;
            end
         end else if (DATA !== 8'h00) begin
            dirty++;
         end
         if (DONE) begin
            ndone++;
            check("gap_quiet", {IVALID, DATA}, 0);
            check("gap_busy", BUSY, 1);
         end
      end
      check("first_latency", first_cyc, 1);
      check("no_bubble", bubbles, 0);
      check("data_zero_idle", dirty, 0);
      check("mode_hold", mflip, 0);
      check("idle_after", BUSY, 0);
   endtask

   // Model-driven request: expected bytes, DONE count and leading-zero loopback.
   task automatic req_check(input logic [5:0] n, input logic m, input bit poke);
      int nb, nd, b;
      logic [31:0] rx, w, mask;
      lfsr_m = lfsr_step(lfsr_m);
      w = model_word(int'(n), lfsr_m);
      b = (!m || n == 6'd32) ? 4 : int'(n) / 8 + 1;
      mask = 32'hFFFF_FFFF << (8 * (4 - b));
      do_req(n, m, poke, nb, rx, nd);
      check("byte_count", nb, b);
      check("word", rx, w & mask);
      check("done_once", nd, 1);
      check("loopback_zeros", clz(rx), int'(n));
   endtask

   initial begin
      int nb, nd, ivs, errs, bsy;
      logic [31:0] rx;

      RST = 1'b1; START = 1'b0; ZEROS_IN = '0; MODE_IN = 1'b0;
      repeat (2) @(negedge CLK);
      check("rst_outputs", {DATA, IVALID, MODE, BUSY, DONE, ERR}, 0);
      RST = 1'b0;
      lfsr_m = 16'hACE1;
      @(negedge CLK);
      check("idle_busy", BUSY, 0);

      // n=0, full word: LFSR 5670 -> D670A98F
      do_req(6'd0, 1'b0, 1'b0, nb, rx, nd);
      lfsr_m = 16'h5670;
      check("n0_bytes", nb, 4);
      check("n0_word", rx, 32'hD670A98F);
      check("n0_done", nd, 1);

      // n=11, stop at leading one: LFSR AB38 -> bytes 00 18
      do_req(6'd11, 1'b1, 1'b0, nb, rx, nd);
      lfsr_m = 16'hAB38;
      check("n11_bytes", nb, 2);
      check("n11_word", rx, 32'h0018_0000);
      check("n11_done", nd, 1);

      // n=32 sends four zero bytes even in stop mode
      req_check(6'd32, 1'b1, 1'b0);

      // n=40 is rejected: ERR pulse only, no burst, LFSR untouched
      ZEROS_IN = 6'd40; MODE_IN = 1'b1; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      check("err_pulse", ERR, 1);
      check("err_busy", BUSY, 0);
      ivs = 0; errs = 0; bsy = 0;
      repeat (4) begin
         @(negedge CLK);
         ivs += int'(IVALID); errs += int'(ERR); bsy += int'(BUSY);
      end
      check("err_single", errs, 0);
      check("err_no_ivalid", ivs, 0);
      check("err_no_busy", bsy, 0);

      // START during SEND is ignored
      req_check(6'd5, 1'b0, 1'b1);
      req_check(6'd20, 1'b1, 1'b1);

      // Reset during the second byte drops the burst
      ZEROS_IN = 6'd0; MODE_IN = 1'b0; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      check("pre_rst_ivalid", IVALID, 1);
      #1 RST = 1'b1;
      #1;
      check("rst_ivalid", IVALID, 0);
      check("rst_data", DATA, 0);
      check("rst_busy", BUSY, 0);
      @(negedge CLK);
      RST = 1'b0;
      nd = 0;
      repeat (4) begin
         @(negedge CLK);
         nd += int'(DONE);
      end
      check("rst_no_done", nd, 0);

      // First request after reset restarts the LFSR: n=4 -> 0E70A98F
      do_req(6'd4, 1'b0, 1'b0, nb, rx, nd);
      lfsr_m = 16'h5670;
      check("post_rst_bytes", nb, 4);
      check("post_rst_word", rx, 32'h0E70A98F);
      check("post_rst_done", nd, 1);

      // Sweep every legal n in both modes
      for (int m = 0; m < 2; m++) begin
         for (int n = 0; n <= 32; n++) begin
            req_check(6'(n), 1'(m), 1'b0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
